// File: rtl/score_bcd_counter.sv
// Dino Run score source: 4-digit BCD score, prescaled by run time, registered 7-seg digit feed.
// Optional high-score register and capture logic enabled by defining SCORE_HISCORE_EN.
module score_bcd_counter #(
  parameter int TICKS_PER_POINT = 100
) (
  input  logic       clk_1k_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic       clear_i,
  input  logic       game_over_i,
  input  logic       show_high_i,
  output logic [3:0] digit0_o,
  output logic [3:0] digit1_o,
  output logic [3:0] digit2_o,
  output logic [3:0] digit3_o,
  output logic       digit0_en_o,
  output logic       digit1_en_o,
  output logic       digit2_en_o,
  output logic       digit3_en_o,
  output logic       saturated_o,
  output logic       new_high_o
);

  localparam int PSW =
    (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam logic [PSW-1:0] PS_MAX = PSW'(TICKS_PER_POINT - 1);
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  logic [PSW-1:0] r_ps;
  logic [15:0]    r_score;
  logic           r_sat;
  logic [15:0]    r_disp;
  logic [3:0]     r_en;

  logic           w_ps_wrap;
  logic           w_tick;
  logic [15:0]    w_score_inc;
  logic [15:0]    w_sel;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_ps_wrap   = (r_ps == PS_MAX);
  assign w_tick      = run_i & w_ps_wrap & ~clear_i;
  assign w_score_inc = bcd_inc(r_score);

  always_ff @(posedge clk_1k_i) begin
    if (rst_i) begin
      r_ps <= '0;
    end else if (clear_i) begin
      r_ps <= '0;
    end else if (run_i) begin
      r_ps <= w_ps_wrap ? '0 : r_ps + PSW'(1);
    end
  end

  // At 9999 ticks are swallowed and the sticky flag rises
  always_ff @(posedge clk_1k_i) begin
    if (rst_i) begin
      r_score <= '0;
      r_sat   <= 1'b0;
    end else if (clear_i) begin
      r_score <= '0;
      r_sat   <= 1'b0;
    end else begin
      if (r_score == SCORE_MAX) begin
        r_sat <= 1'b1;
      end
      if (w_tick && (r_score != SCORE_MAX)) begin
        r_score <= w_score_inc;
      end
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [15:0] r_hi;
  logic        r_go_q;
  logic        r_new_high;
  logic        w_capture;

  // Packed BCD orders the same as the decimal value
  assign w_capture = game_over_i & ~r_go_q;

  always_ff @(posedge clk_1k_i) begin
    if (rst_i) begin
      r_hi       <= '0;
      r_go_q     <= 1'b0;
      r_new_high <= 1'b0;
    end else begin
      r_go_q     <= game_over_i;
      r_new_high <= 1'b0;
      if (w_capture && (r_score > r_hi)) begin
        r_hi       <= r_score;
        r_new_high <= 1'b1;
      end
    end
  end

  assign w_sel      = show_high_i ? r_hi : r_score;
  assign new_high_o = r_new_high;
`else
  logic w_unused_hiscore_ins;

  assign w_unused_hiscore_ins = game_over_i ^ show_high_i;
  assign w_sel                = r_score;
  assign new_high_o           = 1'b0;
`endif

  always_ff @(posedge clk_1k_i) begin
    if (rst_i) begin
      r_disp <= '0;
      r_en   <= 4'b0001;
    end else begin
      r_disp <= w_sel;
      r_en   <= {
        (w_sel[15:12] != 4'd0),
        (w_sel[15:8]  != 8'd0),
        (w_sel[15:4]  != 12'd0),
        1'b1
      };
    end
  end

  assign digit0_o    = r_disp[3:0];
  assign digit1_o    = r_disp[7:4];
  assign digit2_o    = r_disp[11:8];
  assign digit3_o    = r_disp[15:12];
  assign digit0_en_o = r_en[0];
  assign digit1_en_o = r_en[1];
  assign digit2_en_o = r_en[2];
  assign digit3_en_o = r_en[3];
  assign saturated_o = r_sat;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed bench for score_bcd_counter: TICKS_PER_POINT=4 main instance, TICKS_PER_POINT=1 side instance.
// High-score checks adapt to whether SCORE_HISCORE_EN is defined.
module tb_score_bcd_counter;

  logic clk;
  logic rst, run, clr, go, shi;
  logic rst1, run1;

  logic [3:0] d0, d1, d2, d3;
  logic       e0, e1, e2, e3;
  logic       sat, nh;

  logic [3:0] f0, f1, f2, f3;
  logic       g0, g1, g2, g3;
  logic       sat1, nh1;

  int n_pass;
  int n_chk;

  score_bcd_counter #(.TICKS_PER_POINT(4)) dut (
    .clk_1k_i(clk), .rst_i(rst), .run_i(run), .clear_i(clr),
    .game_over_i(go), .show_high_i(shi),
    .digit0_o(d0), .digit1_o(d1), .digit2_o(d2), .digit3_o(d3),
    .digit0_en_o(e0), .digit1_en_o(e1),
    .digit2_en_o(e2), .digit3_en_o(e3),
    .saturated_o(sat), .new_high_o(nh)
  );

  score_bcd_counter #(.TICKS_PER_POINT(1)) dut1 (
    .clk_1k_i(clk), .rst_i(rst1), .run_i(run1), .clear_i(1'b0),
    .game_over_i(1'b0), .show_high_i(1'b0),
    .digit0_o(f0), .digit1_o(f1), .digit2_o(f2), .digit3_o(f3),
    .digit0_en_o(g0), .digit1_en_o(g1),
    .digit2_en_o(g2), .digit3_en_o(g3),
    .saturated_o(sat1), .new_high_o(nh1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          run;
    bit          clr;
    int          n;
    logic [15:0] dig;
    logic [3:0]  en;
    bit          sat;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_main(input string nm, input logic [15:0] dig,
                          input logic [3:0] en, input bit s);
    chk({nm, "_dig"}, int'({d3, d2, d1, d0}), int'(dig));
    chk({nm, "_en"},  int'({e3, e2, e1, e0}), int'(en));
    chk({nm, "_sat"}, int'(sat), int'(s));
    chk({nm, "_nh"},  int'(nh), 0);
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    rst = 1'b1; run = 1'b0; clr = 1'b0; go = 1'b0; shi = 1'b0;
    rst1 = 1'b1; run1 = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 40,    16'h0010, 4'b0011, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 356,   16'h0099, 4'b0011, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3,     16'h0099, 4'b0011, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1,     16'h0100, 4'b0111, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2,     16'h0100, 4'b0111, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 5,     16'h0100, 4'b0111, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1,     16'h0100, 4'b0111, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1,     16'h0101, 4'b0111, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 39591, 16'h9998, 4'b1111, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 10,    16'h9999, 4'b1111, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1,     16'h0000, 4'b0001, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 3,     16'h0000, 4'b0001, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1,     16'h0000, 4'b0001, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 3,     16'h0000, 4'b0001, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1,     16'h0001, 4'b0001, 1'b0};

    step(1);
    chk_main("reset", 16'h0000, 4'b0001, 1'b0);
    rst = 1'b0;

    // Each vector: drive for n cycles, then one idle cycle so the display catches up
    for (int i = 0; i < NV; i++) begin
      run = vecs[i].run;
      clr = vecs[i].clr;
      step(vecs[i].n);
      run = 1'b0;
      clr = 1'b0;
      step(1);
      chk_main($sformatf("v%0d", i), vecs[i].dig, vecs[i].en, vecs[i].sat);
    end

    // Score 0001 -> 0042, then a held game-over level
    run = 1'b1;
    step(164);
    run = 1'b0;
    step(1);
    chk_main("s42", 16'h0042, 4'b0011, 1'b0);
    go = 1'b1;
    step(1);
`ifdef SCORE_HISCORE_EN
    chk("go_pulse", int'(nh), 1);
`else
    chk("go_pulse", int'(nh), 0);
`endif
    step(1);
    chk("go_pulse_end", int'(nh), 0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk($sformatf("go_hold%0d", k), int'(nh), 0);
    end
    shi = 1'b1;
    step(1);
    chk("show_hi_dig", int'({d3, d2, d1, d0}), 'h0042);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
`ifdef SCORE_HISCORE_EN
    chk("show_hi_kept", int'({d3, d2, d1, d0}), 'h0042);
`else
    chk("show_hi_kept", int'({d3, d2, d1, d0}), 'h0000);
`endif
    shi = 1'b0;
    step(1);
    chk("show_score", int'({d3, d2, d1, d0}), 'h0000);

    // Equal score on a fresh capture: no pulse
    go = 1'b0;
    run = 1'b1;
    step(168);
    run = 1'b0;
    step(1);
    chk("eq42_dig", int'({d3, d2, d1, d0}), 'h0042);
    go = 1'b1;
    step(1);
    chk("eq_pulse", int'(nh), 0);
    step(1);
    chk("eq_pulse2", int'(nh), 0);
    go = 1'b0;

    // TICKS_PER_POINT = 1
    step(1);
    rst1 = 1'b0;
    run1 = 1'b1;
    step(12);
    run1 = 1'b0;
    step(1);
    chk("t1_dig", int'({f3, f2, f1, f0}), 'h0012);
    chk("t1_en", int'({g3, g2, g1, g0}), 'b0011);
    run1 = 1'b1;
    step(5);
    rst1 = 1'b1;
    step(1);
    chk("t1_rst_dig", int'({f3, f2, f1, f0}), 'h0000);
    chk("t1_rst_en", int'({g3, g2, g1, g0}), 'b0001);
    chk("t1_rst_sat", int'(sat1), 0);
    chk("t1_rst_nh", int'(nh1), 0);
    rst1 = 1'b0;
    run1 = 1'b0;
    step(1);
    chk("t1_after_rst", int'({f3, f2, f1, f0}), 'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
